reg_mask_encoder: RTL and testbench
===================================

// Module: reg_mask_encoder
// PURPOSE
//  Converts a 32-bit register mask back into a stream of 5-bit register addresses.
//  This is the inverse direction of the register-address decoder: a mask in, addresses out.
//  Emits one address per handshake, lowest set bit first, with a last flag.
//  Serves scoreboard flush and register-file save/restore sequencing in the pipeline.
// PARAMETERS
//  NREGS    32  number of architectural registers (mask width)
//  AW       5   address width, clog2(NREGS)
//  SKIP_X0  1   1: bit 0 (x0) is cleared on capture and never emitted
// PORTS
//  clk        in   1      rising-edge clock, the single clock of the block
//  reset      in   1      synchronous, active-high reset
//  mask_valid in   1      upstream presents a mask
//  mask_ready out  1      block can capture a mask this cycle
//  mask       in   NREGS  register mask, bit i = register i
//  adr_valid  out  1      adr/adr_last hold a valid beat
//  adr_ready  in   1      downstream accepts the beat
//  adr        out  AW     register address of the current beat
//  adr_last   out  1      current beat is the final one for this mask
//  done       out  1      one-cycle pulse: current mask fully emitted
//  count      out  AW+1   beats accepted so far for the current mask
// BEHAVIOUR
//  Reset (sync, active-high, takes priority over all events): state=IDLE, pend=0,
//   mask_ready=1, adr_valid=0, adr=0, adr_last=0, done=0, count=0.
//  States: IDLE, BUSY.
//  Capture: mask_valid&&mask_ready at edge N -> pend=mask (bit0 cleared if SKIP_X0), count=0.
//   If the masked value is nonzero -> BUSY; adr_valid=1 from cycle N+1 (latency 1).
//   If the masked value is zero -> stay or go IDLE, no beats, done=1 at cycle N+1.
//  BUSY: adr = index of lowest set bit of pend; adr_last = (popcount(pend)==1).
//   adr, adr_last and adr_valid are stable while adr_valid&&!adr_ready (AXI-style hold).
//   On beat handshake: clear that bit in pend, count=count+1.
//   On a handshake with adr_last: done=1 next cycle; adr_valid drops unless a new mask is captured.
//  mask_ready = (state==IDLE) || (adr_valid && adr_ready && adr_last).
//   A mask captured in the same cycle as the last beat produces no bubble.
//   Its first beat is valid the next cycle; done still pulses for the old mask.
//  mask is ignored while mask_ready=0; mask_valid may stay high with no effect.
//  count saturates at NREGS (max 31 with SKIP_X0=1, 32 otherwise); it is never wider than AW+1.
//  Reset during BUSY abandons pend with no done pulse; outputs go to reset values next edge.
//  There is no combinational path from adr_ready to adr/adr_valid.
//   mask_ready does depend combinationally on adr_ready (last-beat overlap).
// STRUCTURE
//  Shared package (rv_regfile_pkg): NREGS, AW, REG_X0 constant, state enum {IDLE,BUSY}.
//  Sub-module: pri_enc32to5, combinational lowest-set-bit encoder.
//   Inputs: vec[NREGS-1:0]. Outputs: idx[AW-1:0], any, one (popcount==1).
//   It is instantiated once on pend.
//  The top level holds the pend register, the FSM, count, and the done/adr output registers.
// TESTING
//  1. mask=0x0000_0016, adr_ready=1 -> beats adr=1,2,4 on consecutive cycles.
//     adr_last only on 4; done one cycle later; count=3.
//  2. mask=0x0000_0001 with SKIP_X0=1 -> no adr_valid; done pulses at N+1.
//     Same for mask=0; mask_ready stays 1.
//  3. mask=0x8000_0300 with adr_ready toggling 0/1 -> adr=8,9,31 in order.
//     adr/adr_last held stable during every stall cycle; no beat dropped or duplicated.
//  4. Back-to-back masks 0x0000_0006 then 0x0000_0080, second held valid early.
//     Second captured on the adr=2 (last) handshake; adr=7 valid the next cycle with no gap.
//  5. mask=0xFFFF_FFFF -> 31 beats adr=1..31 with adr_last on 31; count=31.
//     Repeat with SKIP_X0=0 -> 32 beats 0..31; count=32.
//  6. mask=0x00F0_0000, assert reset after 2 beats -> next cycle adr_valid=0, mask_ready=1, count=0.
//     No done pulse; a new mask 0x2 then yields a single beat adr=1.

Source files
------------

// File: rtl/rv_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv_regfile_pkg
//  Description : Shared register-file constants and the mask-encoder state
//                type used by reg_mask_encoder and pri_enc32to5.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_regfile_pkg;

    // Number of architectural registers, i.e. the register-mask width.
    localparam int NREGS  = 32;

    // Register address width, clog2(NREGS).
    localparam int AW     = 5;

    // Bit position of the hard-wired zero register.
    localparam int REG_X0 = 0;

    // Encoder control state: waiting for a mask, or emitting addresses.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage : rv_regfile_pkg
`default_nettype wire

// File: rtl/pri_enc32to5.sv
`default_nettype none
// ============================================================================
//  Module      : pri_enc32to5
//  Description : Combinational lowest-set-bit priority encoder. Reports the
//                index of the lowest set bit, whether any bit is set, and
//                whether exactly one bit is set.
//  Revision    : 1.0  initial release
// ============================================================================
module pri_enc32to5
    import rv_regfile_pkg::*;
(
    input  logic [NREGS-1:0] vec,
    output logic [AW-1:0]    idx,
    output logic             any,
    output logic             one
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[AW-1:0];
            end
        end
    end

    // Exactly one bit set <=> nonzero and clearing the lowest bit leaves zero.
    always_comb begin
        any = |vec;
        one = any && ((vec & (vec - NREGS'(1))) == '0);
    end

endmodule : pri_enc32to5
`default_nettype wire

// File: rtl/reg_mask_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_mask_encoder
//  Description : Turns a register mask into a stream of register addresses,
//                lowest set bit first, one address per handshake, with a last
//                flag, a done pulse and a running beat count. A new mask can
//                be taken on the same cycle as the final beat of the previous
//                one, so consecutive masks stream without a bubble.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_mask_encoder
    import rv_regfile_pkg::*;
#(
    parameter int SKIP_X0 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mask_valid,
    output logic             mask_ready,
    input  logic [NREGS-1:0] mask,
    output logic             adr_valid,
    input  logic             adr_ready,
    output logic [AW-1:0]    adr,
    output logic             adr_last,
    output logic             done,
    output logic [AW:0]      count
);

    localparam logic [AW:0] c_COUNT_MAX = (AW + 1)'(NREGS);
    localparam logic [AW:0] c_COUNT_ONE = (AW + 1)'(1);

    state_e           state_q;
    state_e           state_d;
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             done_q;
    logic             done_d;

    logic [NREGS-1:0] w_masked;
    logic [AW-1:0]    w_idx;
    logic             w_any;
    logic             w_one;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_capture;
    logic             w_masked_nz;

    // Single encoder on the pending set; address and last flag come straight
    // from registered state, so adr_ready never reaches adr or adr_valid.
    pri_enc32to5 u_pri_enc (
        .vec (pend_q),
        .idx (w_idx),
        .any (w_any),
        .one (w_one)
    );

    // Incoming mask with x0 removed when x0 is never to be emitted.
    always_comb begin
        w_masked = mask;
        if (SKIP_X0 != 0) begin
            w_masked[REG_X0] = 1'b0;
        end
        w_masked_nz = |w_masked;
    end

    // Output beat and handshake decode; the last-beat overlap makes
    // mask_ready depend on adr_ready.
    always_comb begin
        adr_valid   = (state_q == BUSY) && w_any;
        adr         = w_idx;
        adr_last    = adr_valid && w_one;
        w_beat      = adr_valid && adr_ready;
        w_last_beat = w_beat && adr_last;
        mask_ready  = (state_q == IDLE) || w_last_beat;
        w_capture   = mask_valid && mask_ready;
        done        = done_q;
        count       = count_q;
    end

    // Next-state: a capture overrides the retiring beat of the old mask.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        done_d  = 1'b0;

        if (w_beat) begin
            // Clearing the lowest set bit retires exactly the emitted address.
            pend_d = pend_q & (pend_q - NREGS'(1));
            if (count_q < c_COUNT_MAX) begin
                count_d = count_q + c_COUNT_ONE;
            end
            if (w_last_beat) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (w_capture) begin
            pend_d  = w_masked;
            count_d = '0;
            if (w_masked_nz) begin
                state_d = BUSY;
            end else begin
                // Empty mask: nothing to emit, report completion next cycle.
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // State, pending-set, count and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

endmodule : reg_mask_encoder
`default_nettype wire

// File: tb/tb_reg_mask_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_mask_encoder
//  Description : Directed self-checking bench for reg_mask_encoder. Expected
//                beats are queued when a mask is accepted and popped as the
//                DUT emits them. Two instances cover SKIP_X0=1 and SKIP_X0=0.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_mask_encoder;

    logic        clk;
    logic        reset;
    logic        mask_valid;
    logic        adr_ready;
    logic [31:0] mask;
    logic        sel;          // 0: SKIP_X0=1 instance, 1: SKIP_X0=0 instance

    logic        mr1, av1, al1, d1;
    logic [4:0]  a1;
    logic [5:0]  c1;
    logic        mr0, av0, al0, d0;
    logic [4:0]  a0;
    logic [5:0]  c0;
    logic        mv1, mv0;

    logic        o_mask_ready, o_adr_valid, o_adr_last, o_done;
    logic [4:0]  o_adr;
    logic [5:0]  o_count;

    assign mv1          = mask_valid & ~sel;
    assign mv0          = mask_valid & sel;
    assign o_mask_ready = sel ? mr0 : mr1;
    assign o_adr_valid  = sel ? av0 : av1;
    assign o_adr        = sel ? a0  : a1;
    assign o_adr_last   = sel ? al0 : al1;
    assign o_done       = sel ? d0  : d1;
    assign o_count      = sel ? c0  : c1;

    reg_mask_encoder #(.SKIP_X0(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mask_valid (mv1),
        .mask_ready (mr1),
        .mask       (mask),
        .adr_valid  (av1),
        .adr_ready  (adr_ready),
        .adr        (a1),
        .adr_last   (al1),
        .done       (d1),
        .count      (c1)
    );

    reg_mask_encoder #(.SKIP_X0(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .mask_valid (mv0),
        .mask_ready (mr0),
        .mask       (mask),
        .adr_valid  (av0),
        .adr_ready  (adr_ready),
        .adr        (a0),
        .adr_last   (al0),
        .done       (d0),
        .count      (c0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: {address, last}
    logic [5:0] q[$];
    int  n_cmp;
    int  n_bad;
    int  cnt_m;
    int  nbeats;
    int  mode;        // 0: adr_ready held 1, 1: adr_ready toggles
    bit  done_exp;
    bit  taken;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mask(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i] && !(!sel && i == 0)) begin
                q.push_back({i[4:0], 1'b0});
                n++;
            end
        end
        if (n > 0) q[q.size() - 1][0] = 1'b1;
        else       done_exp = 1'b1;
    endtask

    task automatic present(input logic [31:0] m);
        mask       = m;
        mask_valid = 1'b1;
    endtask

    // One clock: check at negedge, update model, advance past posedge.
    task automatic cycle();
        bit ev, fl, er;
        @(negedge clk);
        ev = (q.size() != 0);
        fl = ev && q[0][0];
        er = !ev || (adr_ready && fl);
        chk("done", o_done, done_exp);
        done_exp = 1'b0;
        chk("adr_valid", o_adr_valid, ev);
        chk("mask_ready", o_mask_ready, er);
        chk("count", o_count, cnt_m);
        if (ev) begin
            chk("adr", o_adr, q[0][5:1]);
            chk("adr_last", o_adr_last, fl);
        end
        if (ev && adr_ready) begin
            void'(q.pop_front());
            nbeats++;
            if (cnt_m < 32) cnt_m++;
            if (fl) done_exp = 1'b1;
        end
        if (mask_valid && er) begin
            cnt_m = 0;
            push_mask(mask);
            taken = 1'b1;
        end
        @(posedge clk);
        #1;
        if (taken) mask_valid = 1'b0;
        taken = 1'b0;
        if (mode == 1) adr_ready = ~adr_ready;
        else           adr_ready = 1'b1;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((q.size() != 0 || done_exp || mask_valid) && k < limit) begin
            cycle();
            k++;
        end
        chk("drain_in_budget", 32'(k < limit), 32'd1);
        cycle();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        mask_valid = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        q.delete();
        cnt_m    = 0;
        done_exp = 1'b0;
        taken    = 1'b0;
    endtask

    initial begin
        int k;
        n_cmp = 0; n_bad = 0; cnt_m = 0; nbeats = 0; mode = 0;
        done_exp = 0; taken = 0;
        reset = 1'b1; mask_valid = 1'b0; adr_ready = 1'b1; mask = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        cycle();                                   // reset state

        // 1: three beats 1,2,4 back to back
        nbeats = 0; present(32'h0000_0016); drain(20);
        chk("t1_beats", nbeats, 3);

        // 2: x0-only mask and empty mask: no beats, done only
        nbeats = 0; present(32'h0000_0001); drain(10);
        present(32'h0000_0000); drain(10);
        chk("t2_beats", nbeats, 0);

        // 3: stalls with toggling adr_ready
        nbeats = 0; mode = 1; adr_ready = 1'b0;
        present(32'h8000_0300); drain(30);
        chk("t3_beats", nbeats, 3);
        mode = 0; adr_ready = 1'b1;

        // 4: second mask held early, captured on the last beat of the first
        nbeats = 0; present(32'h0000_0006); cycle();
        present(32'h0000_0080); drain(20);
        chk("t4_beats", nbeats, 3);

        // 5a: all ones with x0 skipped
        nbeats = 0; present(32'hFFFF_FFFF); drain(60);
        chk("t5a_beats", nbeats, 31);
        chk("t5a_count", o_count, 31);

        // 6: reset after two beats abandons the mask
        nbeats = 0; present(32'h00F0_0000);
        k = 0;
        while (nbeats < 2 && k < 20) begin cycle(); k++; end
        chk("t6_two_beats", nbeats, 2);
        do_reset();
        cycle();
        nbeats = 0; present(32'h0000_0002); drain(10);
        chk("t6_beats", nbeats, 1);

        // 5b: all ones with x0 emitted
        sel = 1'b1; do_reset();
        nbeats = 0; present(32'hFFFF_FFFF); drain(60);
        chk("t5b_beats", nbeats, 32);
        chk("t5b_count", o_count, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg_mask_encoder
`default_nettype wire
